serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 13 +
 rtl/serial_adder_ctrl_fa.sv | 14 +
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 tb/tb_serial_adder_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder cell used as the serial datapath.
// Ports: CIN, A, B in; S (sum), COUT (carry) out.
module serial_adder_ctrl_fa (
  input  logic CIN,
  input  logic A,
  input  logic B,
  output logic S,
  output logic COUT
);

  assign S    = A ^ B ^ CIN;
  assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit/clock.
// In: CLK, RST, IN_VALID/A/B/CIN; OUT_READY. Out: IN_READY, OUT_VALID, S, COUT, OVF, BUSY.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_cout;

  serial_adder_ctrl_fa u_fa (
    .CIN  (carry),
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .S    (fa_s),
    .COUT (fa_cout)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign s_next = {fa_s, s_sh[WIDTH-1:1]};

  assign IN_READY = (state == IDLE);
  assign BUSY     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      S         <= '0;
      COUT      <= 1'b0;
      OVF       <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= CIN;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_sh  <= s_next;
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            S         <= s_next;
            COUT      <= fa_cout;
            // carry still holds the carry into the MSB here
            OVF       <= carry ^ fa_cout;
            OUT_VALID <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Vector table, backpressure, mid-run reset and a random stream.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] S;
  logic         COUT;
  logic         OVF;
  logic         BUSY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S         (S),
    .COUT      (COUT),
    .OVF       (OVF),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int   edges;
    logic bad;
    A = v.a;
    B = v.b;
    CIN = v.cin;
    IN_VALID = 1'b1;
    chk({tag, " in_ready"}, 64'(IN_READY), 64'd1);
    tick();
    IN_VALID = 1'b0;
    A = ~v.a;
    B = ~v.b;
    edges = 0;
    bad = 1'b0;
    while (!OUT_VALID && edges < 40) begin
      if (!BUSY || IN_READY) bad = 1'b1;
      tick();
      edges++;
    end
    chk({tag, " latency"}, 64'(edges), 64'(W));
    chk({tag, " run flags"}, 64'(bad), 64'd0);
    chk({tag, " s"}, 64'(S), 64'(v.s));
    chk({tag, " cout"}, 64'(COUT), 64'(v.cout));
    chk({tag, " ovf"}, 64'(OVF), 64'(v.ovf));
    chk({tag, " done flags"}, 64'({BUSY, IN_READY}), 64'b10);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, " idle flags"}, 64'({OUT_VALID, IN_READY, BUSY}), 64'b010);
    chk({tag, " s held"}, 64'({COUT, OVF, S}), 64'({v.cout, v.ovf, v.s}));
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] hs;
    logic         hc;
    logic         ho;
    logic         bad;
    logic [W:0]   full;
    int           edges;
    int           last_acc;
    int           min_gap;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    RST = 1'b1;
    tick();
    tick();
    chk("reset in_ready", 64'(IN_READY), 64'd1);
    chk("reset out_valid", 64'(OUT_VALID), 64'd0);
    chk("reset busy", 64'(BUSY), 64'd0);
    chk("reset result", 64'({COUT, OVF, S}), 64'd0);
    RST = 1'b0;
    tick();

    // idle with OUT_READY high: nothing happens
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("idle out_ready", 64'({OUT_VALID, IN_READY, BUSY}), 64'b010);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // backpressure: hold result 5 cycles while IN_VALID toggles
    v = vecs[0];
    A = v.a;
    B = v.b;
    CIN = v.cin;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    edges = 0;
    while (!OUT_VALID && edges < 40) begin
      tick();
      edges++;
    end
    chk("bp latency", 64'(edges), 64'(W));
    hs = S;
    hc = COUT;
    ho = OVF;
    chk("bp result", 64'({hc, ho, hs}), 64'({v.cout, v.ovf, v.s}));
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      IN_VALID = i[0];
      A = 8'hC3;
      B = 8'h11;
      tick();
      if (!OUT_VALID || S !== hs || COUT !== hc || OVF !== ho ||
          IN_READY || !BUSY) bad = 1'b1;
    end
    IN_VALID = 1'b0;
    chk("bp stable", 64'(bad), 64'd0);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("bp release", 64'({OUT_VALID, IN_READY, BUSY}), 64'b010);
    tick();
    chk("bp no capture", 64'({IN_READY, BUSY}), 64'b10);

    // reset while bit 3 is being processed
    A = 8'hAA;
    B = 8'h55;
    CIN = 1'b1;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst mid flags", 64'({OUT_VALID, IN_READY, BUSY}), 64'b010);
    chk("rst mid result", 64'({COUT, OVF, S}), 64'd0);
    tick();
    chk("rst mid idle", 64'({OUT_VALID, IN_READY, BUSY}), 64'b010);
    do_op(vecs[6], "post rst");

    // back-to-back random stream against an arithmetic model
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    last_acc = -1000;
    min_gap = 1000;
    bad = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      A = W'($urandom);
      B = W'($urandom);
      CIN = 1'($urandom);
      full = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, CIN};
      ho = (A[W-1] == B[W-1]) && (full[W-1] != A[W-1]);
      edges = 0;
      while (!IN_READY && edges < 40) begin
        tick();
        edges++;
      end
      if (edges >= 40) bad = 1'b1;
      @(posedge CLK);
      if (cyc - last_acc < min_gap) min_gap = cyc - last_acc;
      last_acc = cyc;
      #1;
      edges = 0;
      while (!OUT_VALID && edges < 40) begin
        tick();
        edges++;
      end
      if (edges >= 40) bad = 1'b1;
      chk($sformatf("rand%0d", n), 64'({COUT, S, OVF}), 64'({full, ho}));
      tick();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    chk("rand timeouts", 64'(bad), 64'd0);
    chk("rand min gap ok", 64'(min_gap >= W + 2), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
